// File: rtl/mult_bist_pkg.sv
// Shared types and default parameters for the multiplier self-test sequencer.
package mult_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_W       = 2;
    localparam int DEF_LATENCY = 0;
    localparam int DEF_ERR_W   = 8;

endpackage : mult_bist_pkg

// File: rtl/mult_bist_if.sv
// Pin-level bus between the self-test sequencer (master) and the multiplier under test (slave).
interface mult_bist_if #(
    parameter int W = 2
);
    logic [W-1:0]   dut_a;
    logic [W-1:0]   dut_b;
    logic [2*W-1:0] dut_p;

    modport master (output dut_a, output dut_b, input dut_p);
    modport slave  (input dut_a, input dut_b, output dut_p);

endinterface : mult_bist_if

// File: rtl/mult_bist_ref.sv
// Combinational golden multiplier: unsigned W x W -> 2W, used as the checker's reference.
module mult_bist_ref #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Zero-extend both operands first so the product is formed at full width.
    assign p = (2*W)'(a) * (2*W)'(b);

endmodule : mult_bist_ref

// File: rtl/mult_bist.sv
// Exhaustive self-test sequencer for a small unsigned multiplier: sweeps all
// operand pairs, waits the DUT latency, checks each product and records errors.
module mult_bist
    import mult_bist_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int ERR_W   = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    mult_bist_if.master      bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [W-1:0]     fail_a,
    output logic [W-1:0]     fail_b,
    output logic [2*W-1:0]   fail_p
);

    localparam int CNT_W  = 2 * W;
    localparam int WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [W-1:0]       fail_a_q, fail_a_d;
    logic [W-1:0]       fail_b_q, fail_b_d;
    logic [2*W-1:0]     fail_p_q, fail_p_d;
    logic               flag_q, flag_d;
    logic [W-1:0]       dut_a_q, dut_a_d;
    logic [W-1:0]       dut_b_q, dut_b_d;
    logic [2*W-1:0]     ref_p;
    logic               mismatch;

    mult_bist_ref #(.W(W)) u_ref (
        .a (dut_a_q),
        .b (dut_b_q),
        .p (ref_p)
    );

    assign mismatch = (bus.dut_p != ref_p);

    // Next-state, counter and capture logic for the sweep FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        err_d    = err_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
        fail_p_d = fail_p_q;
        flag_d   = flag_q;
        dut_a_d  = '0;
        dut_b_d  = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d    = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                    fail_p_d = '0;
                    flag_d   = 1'b0;
                    wait_d   = WAIT_W'(LATENCY);
                    state_d  = (LATENCY > 0) ? ST_SETTLE : ST_CHECK;
                end
            end
            ST_SETTLE: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q == WAIT_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!flag_q) begin
                        fail_a_d = dut_a_q;
                        fail_b_d = dut_b_q;
                        fail_p_d = bus.dut_p;
                        flag_d   = 1'b1;
                    end
                end
                // Finishing the last vector wins over counter wrap.
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    wait_d  = WAIT_W'(LATENCY);
                    state_d = (LATENCY > 0) ? ST_SETTLE : ST_CHECK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands are registered from the next vector so they line up with the busy window.
        if (state_d == ST_SETTLE || state_d == ST_CHECK) begin
            {dut_a_d, dut_b_d} = cnt_d;
        end
    end

    // State, counters, capture registers and operand outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            fail_p_q <= '0;
            flag_q   <= 1'b0;
            dut_a_q  <= '0;
            dut_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
            fail_p_q <= fail_p_d;
            flag_q   <= flag_d;
            dut_a_q  <= dut_a_d;
            dut_b_q  <= dut_b_d;
        end
    end

    assign bus.dut_a = dut_a_q;
    assign bus.dut_b = dut_b_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_p    = fail_p_q;

endmodule : mult_bist
